// File: rtl/sseg_mux_capture.sv
// sseg_mux_capture
//
// Receive end of the hex-to-segment path. Samples a time-multiplexed,
// active-low seven-segment bus (anodes + segments) and recovers the hex
// value shown on each digit. A digit is published only after its
// (anode, pattern) pair has been seen unchanged for STABLE_CYCLES samples.
// Blank digits clear their valid bit. Stable undecodable patterns raise a
// sticky error.
//
// Optional feature macro: SSEG_CAP_FRAME_EN
//   defined   : frame_done_o pulses once every digit has updated since the
//               last frame pulse
//   undefined : frame_done_o is tied to 0
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   an_i           anode enables, active-low, one low at a time
//   sseg_i         segments, active-low, bit0=a .. bit6=g
//   err_clr_i      clears err_o (a same-cycle new error wins)
//   hex_o          captured nibbles, digit i at [4i+3:4i]
//   digit_valid_o  digit i holds a valid capture
//   update_o       one-cycle pulse per capture (hex or blank)
//   update_idx_o   digit index of the current/last update
//   err_o          sticky error flag
//   err_digit_o    digit index of the most recent error
//   frame_done_o   frame-complete pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no valid digit on the bus, counter cleared
// TRACK    | candidate pair loaded, counting identical samples
// CAPTURED | candidate published, waiting for the bus to change

module sseg_mux_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_DIGITS-1:0]   an_i,
   input  logic [6:0]              sseg_i,
   input  logic                    err_clr_i,
   output logic [4*NUM_DIGITS-1:0] hex_o,
   output logic [NUM_DIGITS-1:0]   digit_valid_o,
   output logic                    update_o,
   output logic [IW-1:0]           update_idx_o,
   output logic                    err_o,
   output logic [IW-1:0]           err_digit_o,
   output logic                    frame_done_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRACK    = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   // Returns {ok, nibble}; ok=0 for anything outside the hex glyph set.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1000000: r = {1'b1, 4'h0};
         7'b1111001: r = {1'b1, 4'h1};
         7'b0100100: r = {1'b1, 4'h2};
         7'b0110000: r = {1'b1, 4'h3};
         7'b0011001: r = {1'b1, 4'h4};
         7'b0010010: r = {1'b1, 4'h5};
         7'b0000010: r = {1'b1, 4'h6};
         7'b1111000: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0010000: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b0000011: r = {1'b1, 4'hB};
         7'b1000110: r = {1'b1, 4'hC};
         7'b0100001: r = {1'b1, 4'hD};
         7'b0000110: r = {1'b1, 4'hE};
         7'b0001110: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   logic [NUM_DIGITS-1:0]   an_q;
   logic [6:0]              sseg_q;

   state_t                  state_d, state_q;
   logic [CW-1:0]           cnt_d, cnt_q;
   logic [IW-1:0]           cand_idx_d, cand_idx_q;
   logic [6:0]              cand_pat_d, cand_pat_q;
   logic [4*NUM_DIGITS-1:0] hex_d, hex_q;
   logic [NUM_DIGITS-1:0]   valid_d, valid_q;
   logic                    update_d, update_q;
   logic [IW-1:0]           update_idx_d, update_idx_q;
   logic                    err_d, err_q;
   logic [IW-1:0]           err_digit_d, err_digit_q;

   logic                    an_found, an_multi, an_ok;
   logic [IW-1:0]           an_idx;
   logic                    pair_same;
   logic                    capture;
   logic [4:0]              dec;

   // Anode word is a digit select only when exactly one bit is low.
   always_comb begin
      an_found = 1'b0;
      an_multi = 1'b0;
      an_idx   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_q[i]) begin
            if (an_found) an_multi = 1'b1;
            an_found = 1'b1;
            an_idx   = IW'(i);
         end
      end
      an_ok = an_found & ~an_multi;
   end

   assign pair_same = an_ok && (an_idx == cand_idx_q) && (sseg_q == cand_pat_q);
   assign dec       = decode_seg(sseg_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cand_idx_d   = cand_idx_q;
      cand_pat_d   = cand_pat_q;
      hex_d        = hex_q;
      valid_d      = valid_q;
      update_d     = 1'b0;
      update_idx_d = update_idx_q;
      err_d        = err_q & ~err_clr_i;
      err_digit_d  = err_digit_q;
      capture      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (an_ok) begin
               cand_idx_d = an_idx;
               cand_pat_d = sseg_q;
               cnt_d      = CNT_ONE;
               state_d    = TRACK;
            end
         end
         TRACK: begin
            if (!an_ok) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (pair_same) begin
               cnt_d = (cnt_q == STABLE_CNT) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
               cand_idx_d = an_idx;
               cand_pat_d = sseg_q;
               cnt_d      = CNT_ONE;
            end
         end
         CAPTURED: begin
            if (!an_ok) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (!pair_same) begin
               cand_idx_d = an_idx;
               cand_pat_d = sseg_q;
               cnt_d      = CNT_ONE;
               state_d    = TRACK;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // Any path that ends up tracking with a full count captures now, which
      // also covers STABLE_CYCLES=1 where the first sample is enough.
      if ((state_d == TRACK) && (cnt_d >= STABLE_CNT)) begin
         capture = 1'b1;
         state_d = CAPTURED;
      end

      if (capture) begin
         if (dec[4]) begin
            hex_d[4*an_idx +: 4] = dec[3:0];
            valid_d[an_idx]      = 1'b1;
            update_d             = 1'b1;
            update_idx_d         = an_idx;
         end else if (sseg_q == SEG_BLANK) begin
            valid_d[an_idx]      = 1'b0;
            update_d             = 1'b1;
            update_idx_d         = an_idx;
         end else begin
            err_d                = 1'b1;
            err_digit_d          = an_idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         an_q         <= '1;
         sseg_q       <= SEG_BLANK;
         state_q      <= IDLE;
         cnt_q        <= '0;
         cand_idx_q   <= '0;
         cand_pat_q   <= SEG_BLANK;
         hex_q        <= '0;
         valid_q      <= '0;
         update_q     <= 1'b0;
         update_idx_q <= '0;
         err_q        <= 1'b0;
         err_digit_q  <= '0;
      end else begin
         an_q         <= an_i;
         sseg_q       <= sseg_i;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cand_idx_q   <= cand_idx_d;
         cand_pat_q   <= cand_pat_d;
         hex_q        <= hex_d;
         valid_q      <= valid_d;
         update_q     <= update_d;
         update_idx_q <= update_idx_d;
         err_q        <= err_d;
         err_digit_q  <= err_digit_d;
      end
   end

   assign hex_o         = hex_q;
   assign digit_valid_o = valid_q;
   assign update_o      = update_q;
   assign update_idx_o  = update_idx_q;
   assign err_o         = err_q;
   assign err_digit_o   = err_digit_q;

`ifdef SSEG_CAP_FRAME_EN
   logic [NUM_DIGITS-1:0] seen_d, seen_q;
   logic                  frame_d, frame_q;

   // The mask fills on the same edge as update_o, so the full mask is seen
   // one cycle later and frame_done_o lands in the cycle after the update.
   always_comb begin
      seen_d  = (&seen_q) ? '0 : seen_q;
      if (update_d) seen_d[update_idx_d] = 1'b1;
      frame_d = &seen_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seen_q  <= '0;
         frame_q <= 1'b0;
      end else begin
         seen_q  <= seen_d;
         frame_q <= frame_d;
      end
   end

   assign frame_done_o = frame_q;
`else
   assign frame_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_mux_capture.sv
// tb_sseg_mux_capture
//
// Directed bench for sseg_mux_capture with NUM_DIGITS=4, STABLE_CYCLES=4.
// Inputs change 1 time unit after the rising edge, outputs are sampled at
// the same point. With SSEG_CAP_FRAME_EN defined the frame pulse is
// expected; otherwise frame_done_o must stay low.

module tb_sseg_mux_capture;

   localparam int ND = 4;
   localparam int SC = 4;

   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BAD   = 7'b0101010;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef SSEG_CAP_FRAME_EN
   localparam logic FRAME_EXP = 1'b1;
   localparam int   FRAME_CNT = 1;
`else
   localparam logic FRAME_EXP = 1'b0;
   localparam int   FRAME_CNT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [ND-1:0] an;
   logic [6:0]    sseg;
   logic          err_clr;
   logic [4*ND-1:0] hex;
   logic [ND-1:0] digit_valid;
   logic          update;
   logic [1:0]    update_idx;
   logic          err;
   logic [1:0]    err_digit;
   logic          frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_seen = 0;
   int frm_seen = 0;
   int upd_base;

   logic [6:0] scan_seg [4];

   sseg_mux_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .an_i          (an),
      .sseg_i        (sseg),
      .err_clr_i     (err_clr),
      .hex_o         (hex),
      .digit_valid_o (digit_valid),
      .update_o      (update),
      .update_idx_o  (update_idx),
      .err_o         (err),
      .err_digit_o   (err_digit),
      .frame_done_o  (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (update)     upd_seen++;
      if (frame_done) frm_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      scan_seg[0] = SEG_3;
      scan_seg[1] = SEG_1;
      scan_seg[2] = SEG_4;
      scan_seg[3] = SEG_1;

      rst_n   = 1'b0;
      an      = '1;
      sseg    = SEG_BLANK;
      err_clr = 1'b0;
      tick(3);
      check("rst_hex",        32'(hex),         32'h0);
      check("rst_valid",      32'(digit_valid), 32'h0);
      check("rst_update",     32'(update),      32'h0);
      check("rst_update_idx", 32'(update_idx),  32'h0);
      check("rst_err",        32'(err),         32'h0);
      check("rst_err_digit",  32'(err_digit),   32'h0);
      check("rst_frame",      32'(frame_done),  32'h0);
      rst_n = 1'b1;
      tick(2);

      // single capture: digit 0 shows 2, update after the 5th edge
      upd_base = upd_seen;
      an   = 4'b1110;
      sseg = SEG_2;
      tick(4);
      check("cap_early_update", 32'(update), 32'h0);
      tick(1);
      check("cap_update",     32'(update),      32'h1);
      check("cap_update_idx", 32'(update_idx),  32'h0);
      check("cap_hex",        32'(hex),         32'h0002);
      check("cap_valid",      32'(digit_valid), 32'b0001);
      tick(1);
      check("cap_pulse_end",  32'(update),      32'h0);
      an = '1;
      tick(2);
      check("cap_one_pulse",  32'(upd_seen - upd_base), 32'd1);

      // glitch: three samples of digit 1 then nothing
      upd_base = upd_seen;
      an   = 4'b1101;
      sseg = SEG_4;
      tick(3);
      an = '1;
      tick(6);
      check("glitch_no_update", 32'(upd_seen - upd_base), 32'd0);
      check("glitch_hex",       32'(hex),         32'h0002);
      check("glitch_valid",     32'(digit_valid), 32'b0001);

      // undecodable pattern on digit 2
      upd_base = upd_seen;
      an   = 4'b1011;
      sseg = SEG_BAD;
      tick(4);
      an = '1;
      tick(1);
      check("err_set",       32'(err),         32'h1);
      check("err_digit",     32'(err_digit),   32'h2);
      check("err_hex",       32'(hex),         32'h0002);
      check("err_valid",     32'(digit_valid), 32'b0001);
      tick(2);
      check("err_no_update", 32'(upd_seen - upd_base), 32'd0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("err_cleared",   32'(err), 32'h0);

      // new error on digit 3 in the same cycle as a clear
      an   = 4'b0111;
      sseg = SEG_BAD;
      tick(4);
      an      = '1;
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("err_clr_collide", 32'(err),       32'h1);
      check("err_digit3",      32'(err_digit), 32'h3);
      tick(1);
      check("err_sticky",      32'(err),       32'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("err_cleared2",    32'(err),       32'h0);

      // two anodes low: no digit at all
      upd_base = upd_seen;
      an   = 4'b1100;
      sseg = SEG_8;
      tick(10);
      check("multi_an_no_update", 32'(upd_seen - upd_base), 32'd0);
      check("multi_an_no_err",    32'(err), 32'h0);

      // blank on digit 0 clears its valid bit but keeps the nibble
      an   = 4'b1110;
      sseg = SEG_BLANK;
      tick(4);
      an = '1;
      tick(1);
      check("blank_update",     32'(update),      32'h1);
      check("blank_update_idx", 32'(update_idx),  32'h0);
      check("blank_valid",      32'(digit_valid), 32'b0000);
      check("blank_hex",        32'(hex),         32'h0002);
      tick(1);
      check("blank_pulse_end",  32'(update),      32'h0);

      // full scan 3,1,4,1 back to back
      for (int i = 0; i < ND; i++) begin
         an   = ~(4'b0001 << i);
         sseg = scan_seg[i];
         tick(5);
         check($sformatf("scan_update_d%0d", i), 32'(update),     32'h1);
         check($sformatf("scan_idx_d%0d", i),    32'(update_idx), 32'(i));
         check($sformatf("scan_frame_d%0d", i),  32'(frame_done), 32'h0);
      end
      check("scan_hex",   32'(hex),         32'h1413);
      check("scan_valid", 32'(digit_valid), 32'b1111);
      an = '1;
      tick(1);
      check("frame_pulse",      32'(frame_done), 32'(FRAME_EXP));
      check("frame_no_update",  32'(update),     32'h0);
      tick(1);
      check("frame_pulse_end",  32'(frame_done), 32'h0);

      // async reset mid-track, then a clean capture from IDLE
      an   = 4'b1101;
      sseg = SEG_9;
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_hex",    32'(hex),         32'h0);
      check("async_rst_valid",  32'(digit_valid), 32'h0);
      check("async_rst_update", 32'(update),      32'h0);
      check("async_rst_idx",    32'(update_idx),  32'h0);
      check("async_rst_frame",  32'(frame_done),  32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(4);
      check("post_rst_early",     32'(update),      32'h0);
      tick(1);
      check("post_rst_update",    32'(update),      32'h1);
      check("post_rst_idx",       32'(update_idx),  32'h1);
      check("post_rst_hex",       32'(hex),         32'h0090);
      check("post_rst_valid",     32'(digit_valid), 32'b0010);
      an = '1;
      tick(2);

      check("total_updates", 32'(upd_seen), 32'd7);
      check("total_frames",  32'(frm_seen), 32'(FRAME_CNT));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
